// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI transmitter between N_REQ requesters.
// Latches the winner's byte, pulses load, waits for done (rising edge) or watchdog, then acks.
module spi_tx_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          ack,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [DATA_W-1:0]         spi_data_in,
    output logic                      spi_load,
    input  logic                      spi_done
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ACK
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       win_q;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    ack_q;
    logic                busy_q;
    logic                terr_q;
    logic [DATA_W-1:0]   data_q;
    logic                load_q;
    logic [TW-1:0]       timer_q;
    logic                done_q;

    logic                found_d;
    logic [IW-1:0]       win_d;
    logic [N_REQ-1:0]    grant_d;
    logic [DATA_W-1:0]   data_d;
    logic                done_rise;

    // Scan ptr+1, ptr+2, ... so the last owner has lowest priority next round.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        grant_d = '0;
        data_d  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!found_d && req[IW'(idx)]) begin
                found_d           = 1'b1;
                win_d             = IW'(idx);
                grant_d[IW'(idx)] = 1'b1;
                data_d            = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign done_rise = spi_done & ~done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            data_q  <= '0;
            load_q  <= 1'b0;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= spi_done;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        state_q <= S_LOAD;
                        win_q   <= win_d;
                        grant_q <= grant_d;
                        data_q  <= data_d;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    load_q  <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done edge on the watchdog's last cycle still counts as a clean completion.
                    if (done_rise) begin
                        state_q <= S_ACK;
                        ack_q   <= grant_q;
                    end else if (timer_q == TMAX) begin
                        state_q <= S_ACK;
                        ack_q   <= grant_q;
                        terr_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    ptr_q   <= win_q;
                    grant_q <= '0;
                    ack_q   <= '0;
                    terr_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    data_q  <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign spi_data_in = data_q;
    assign spi_load    = load_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: stimulus pushes expected loads/acks, a monitor pops and compares.
// A behavioural SPI stub answers each load with a one-cycle done pulse after STUB_D cycles.
module tb_spi_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned TO  = 16;
    localparam int          STUB_D = 3;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [DW-1:0] data;
    } load_exp_t;

    typedef struct packed {
        logic [N-1:0] ack;
        logic         terr;
        int           gap;
    } ack_exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            busy;
    logic            timeout_err;
    logic [DW-1:0]   spi_data_in;
    logic            spi_load;
    logic            spi_done;

    logic stub_auto = 1'b1;
    logic stub_done = 1'b0;
    logic man_done  = 1'b0;
    assign spi_done = stub_done | man_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_load = 0;
    logic post_ack = 1'b0;

    load_exp_t load_q[$];
    ack_exp_t  ack_q[$];

    spi_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .spi_data_in (spi_data_in),
        .spi_load    (spi_load),
        .spi_done    (spi_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (spi_load === 1'b1 && stub_auto) begin
                repeat (STUB_D) @(negedge clk);
                stub_done = 1'b1;
                @(negedge clk);
                stub_done = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        load_exp_t le;
        ack_exp_t  ae;
        forever begin
            @(negedge clk);
            if (post_ack) begin
                checks++;
                if (busy !== 1'b0 || grant !== '0)
                    $display("FAIL post_ack_idle: busy=%b grant=%b required busy=0 grant=0000", busy, grant);
                if (busy !== 1'b0 || grant !== '0) errors++;
                post_ack = 1'b0;
            end
            if (spi_load === 1'b1) begin
                checks++;
                if (load_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: grant=%b data=%h required no load", grant, spi_data_in);
                end else begin
                    le = load_q.pop_front();
                    if (grant !== le.grant || spi_data_in !== le.data || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL load: grant=%b data=%h busy=%b required grant=%b data=%h busy=1",
                                 grant, spi_data_in, busy, le.grant, le.data);
                    end
                end
                last_load = cyc;
            end
            if (ack !== '0) begin
                checks++;
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack=%b terr=%b required no ack", ack, timeout_err);
                end else begin
                    ae = ack_q.pop_front();
                    if (ack !== ae.ack || timeout_err !== ae.terr || (cyc - last_load) != ae.gap) begin
                        errors++;
                        $display("FAIL ack: ack=%b terr=%b gap=%0d required ack=%b terr=%b gap=%0d",
                                 ack, timeout_err, cyc - last_load, ae.ack, ae.terr, ae.gap);
                    end
                end
                post_ack = 1'b1;
            end else if (timeout_err !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL stray_terr: terr=%b required 0", timeout_err);
            end
        end
    end

    function automatic void exp_frame(input logic [N-1:0] g, input logic [DW-1:0] d,
                                      input logic terr, input int gap, input bit with_ack);
        load_exp_t le;
        ack_exp_t  ae;
        le.grant = g;
        le.data  = d;
        load_q.push_back(le);
        if (with_ack) begin
            ae.ack  = g;
            ae.terr = terr;
            ae.gap  = gap;
            ack_q.push_back(ae);
        end
    endfunction

    task automatic check_zero(input string name);
        checks++;
        if ({grant, ack, busy, timeout_err, spi_data_in, spi_load} !== '0) begin
            errors++;
            $display("FAIL %s: grant=%b ack=%b busy=%b terr=%b data=%h load=%b required all 0",
                     name, grant, ack, busy, timeout_err, spi_data_in, spi_load);
        end
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_load !== 1'b1 && n < 200);
        if (spi_load !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_load_timeout: spi_load=%b required 1 within 200 cycles", name, spi_load);
        end
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === '0 && n < 200);
        if (ack === '0) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: ack=%b required nonzero within 200 cycles", name, ack);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        // 1: reset held, then released with no requests
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("idle_no_req");
        end

        // 2: single requester, first winner is requester 0
        req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        exp_frame(4'b0001, 8'hA5, 1'b0, STUB_D + 1, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (spi_load !== 1'b1) begin
            errors++;
            $display("FAIL t2_latency: spi_load=%b required 1", spi_load);
        end
        req = '0;
        wait_ack("t2");
        repeat (3) @(negedge clk);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // 3: all four requesting, rotation 0,1,2,3,0
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        exp_frame(4'b0001, 8'h11, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b0010, 8'h22, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b0100, 8'h33, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b1000, 8'h44, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b0001, 8'h11, 1'b0, STUB_D + 1, 1'b1);
        req = 4'b1111;
        repeat (5) wait_load("t3");
        req = '0;
        wait_ack("t3");
        repeat (3) @(negedge clk);

        // 4: requesters 1 and 3 alternate
        req_data = {8'hC3, 8'h00, 8'h5A, 8'h00};
        exp_frame(4'b0010, 8'h5A, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b1000, 8'hC3, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b0010, 8'h5A, 1'b0, STUB_D + 1, 1'b1);
        exp_frame(4'b1000, 8'hC3, 1'b0, STUB_D + 1, 1'b1);
        req = 4'b1010;
        repeat (4) wait_load("t4");
        req = '0;
        wait_ack("t4");
        repeat (3) @(negedge clk);

        // 5: watchdog on requester 0, then requester 2 served normally
        req_data = {8'h00, 8'h9C, 8'h00, 8'hE1};
        stub_auto = 1'b0;
        exp_frame(4'b0001, 8'hE1, 1'b1, TO + 1, 1'b1);
        exp_frame(4'b0100, 8'h9C, 1'b0, STUB_D + 1, 1'b1);
        req = 4'b0101;
        wait_ack("t5_timeout");
        stub_auto = 1'b1;
        wait_load("t5_next");
        req = '0;
        wait_ack("t5_next");
        repeat (3) @(negedge clk);

        // 6: done already high across LOAD must not complete; needs a fresh rising edge
        stub_auto = 1'b0;
        man_done  = 1'b1;
        req_data  = {8'h00, 8'h00, 8'h3D, 8'h00};
        exp_frame(4'b0010, 8'h3D, 1'b0, 6, 1'b1);
        repeat (2) @(negedge clk);
        req = 4'b0010;
        wait_load("t6");
        req = '0;
        repeat (2) @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);

        // 6b: reset mid-WAIT, then requester 0 wins over 3
        req_data = {8'h7E, 8'h00, 8'h00, 8'h81};
        exp_frame(4'b1000, 8'h7E, 1'b0, 0, 1'b0);
        req = 4'b1000;
        wait_load("t6b");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 check_zero("reset_mid_wait");
        stub_auto = 1'b1;
        req = 4'b1001;
        exp_frame(4'b0001, 8'h81, 1'b0, STUB_D + 1, 1'b1);
        @(negedge clk);
        check_zero("reset_mid_hold");
        reset = 1'b1;
        wait_load("t6c");
        req = '0;
        wait_ack("t6c");
        repeat (5) @(negedge clk);

        checks++;
        if (load_q.size() != 0 || ack_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: loads=%0d acks=%0d required 0 0", load_q.size(), ack_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
